// File: rtl/vip_uart_pkg.sv
// Shared types and constants for the UART receive capture block.
package vip_uart_pkg;

   localparam int unsigned UartDataBits = 8;
   localparam logic [7:0]  UartEol      = 8'h0A;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_e;

endpackage

// File: rtl/vip_uart_rx_capture_if.sv
// Byte stream from the UART capture block to its consumer (valid/ready).
// The capture block drives the master side; the consumer sits on the slave side.
interface vip_uart_rx_capture_if;

   logic [vip_uart_pkg::UartDataBits-1:0] byte_o;
   logic                                  valid_o;
   logic                                  ready_i;
   logic                                  eol_o;

   modport master (
      output byte_o,
      output valid_o,
      output eol_o,
      input  ready_i
   );

   modport slave (
      input  byte_o,
      input  valid_o,
      input  eol_o,
      output ready_i
   );

endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO. With FALL_THROUGH=0 a pushed word is visible on
// data_o the cycle after the push. A push while full is accepted only when a
// pop happens in the same cycle, so the occupancy stays constant.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [AddrDepth:0]    usage_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   logic [AddrDepth-1:0]  readPtr_q;
   logic [AddrDepth-1:0]  writePtr_q;
   logic [AddrDepth:0]    count_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic fallPass;
   logic doPop;
   logic doPush;

   function automatic logic [AddrDepth-1:0] nextPtr(input logic [AddrDepth-1:0] p);
      if (p == AddrDepth'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign full_o   = (count_q == (AddrDepth + 1)'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign usage_o  = count_q;

   // A word pushed into an empty fall-through FIFO and popped at once never gets stored.
   assign fallPass = FALL_THROUGH && empty_o && push_i && pop_i;
   assign doPop    = pop_i && !empty_o;
   assign doPush   = push_i && (!full_o || doPop) && !fallPass;

   // Head of queue, optionally bypassed by the incoming word when empty.
   always_comb begin
      data_o = mem_q[readPtr_q];
      if (FALL_THROUGH && empty_o) begin
         data_o = data_i;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         readPtr_q  <= '0;
         writePtr_q <= '0;
         count_q    <= '0;
      end else if (flush_i) begin
         readPtr_q  <= '0;
         writePtr_q <= '0;
         count_q    <= '0;
      end else begin
         if (doPush) begin
            writePtr_q <= nextPtr(writePtr_q);
         end
         if (doPop) begin
            readPtr_q <= nextPtr(readPtr_q);
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (doPush) begin
         mem_q[writePtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/vip_uart_rx_capture.sv
// UART 8N1 receiver that captures bytes from the SoC TX line into a small
// buffer for the console consumer, flagging framing errors and overflow.
module vip_uart_rx_capture
   import vip_uart_pkg::*;
#(
   parameter int unsigned ClksPerBit = 16,
   parameter int unsigned FifoDepth  = 8,
   localparam int unsigned CntW      = $clog2(ClksPerBit),
   localparam int unsigned FillW     = $clog2(FifoDepth) + 1,
   localparam int unsigned IdxW      = $clog2(UartDataBits)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   rx_i,
   input  logic                   clr_i,
   vip_uart_rx_capture_if.master  cons,
   output logic                   frame_err_o,
   output logic                   overflow_o,
   output logic [FillW-1:0]       fill_o
);

   localparam logic [CntW-1:0] HalfBit = CntW'(ClksPerBit / 2 - 1);
   localparam logic [CntW-1:0] FullBit = CntW'(ClksPerBit - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(UartDataBits - 1);

   logic rxMeta_q;
   logic rxSync_q;
   logic rxPrev_q;

   uart_rx_state_e          state_q;
   logic [CntW-1:0]         bitCnt_q;
   logic [IdxW-1:0]         bitIdx_q;
   logic [UartDataBits-1:0] shift_q;
   logic                    frameErr_q;

   logic                    overflow_q;
   logic                    overflow_d;

   logic                    pushByte;
   logic                    popByte;
   logic                    ovfSet;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic [UartDataBits-1:0] fifoData;
   logic [FillW-1:0]        fifoUsage;

   // Two-flop synchronizer; rxPrev_q keeps the last synchronized level for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
      end
   end

   // Frame decoder: counts down to mid-bit, samples, and tracks bit position.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         frameErr_q <= 1'b0;
      end else begin
         frameErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rxPrev_q && !rxSync_q) begin
                  state_q  <= START;
                  bitCnt_q <= HalfBit;
               end
            end
            START: begin
               if (bitCnt_q == '0) begin
                  if (rxSync_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q  <= DATA;
                     bitIdx_q <= '0;
                     bitCnt_q <= FullBit;
                  end
               end else begin
                  bitCnt_q <= bitCnt_q - 1'b1;
               end
            end
            DATA: begin
               if (bitCnt_q == '0) begin
                  shift_q[bitIdx_q] <= rxSync_q;
                  bitCnt_q          <= FullBit;
                  if (bitIdx_q == LastIdx) begin
                     state_q <= STOP;
                  end else begin
                     bitIdx_q <= bitIdx_q + 1'b1;
                  end
               end else begin
                  bitCnt_q <= bitCnt_q - 1'b1;
               end
            end
            STOP: begin
               if (bitCnt_q == '0) begin
                  if (rxSync_q) begin
                     state_q <= IDLE;
                  end else begin
                     frameErr_q <= 1'b1;
                     state_q    <= BREAK;
                  end
               end else begin
                  bitCnt_q <= bitCnt_q - 1'b1;
               end
            end
            BREAK: begin
               if (rxSync_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A good stop bit sample hands the assembled byte to the buffer.
   assign pushByte = (state_q == STOP) && (bitCnt_q == '0) && rxSync_q;
   assign popByte  = !fifoEmpty && cons.ready_i;
   assign ovfSet   = pushByte && fifoFull && !popByte;

   // Sticky overflow: a new drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (clr_i) begin
         overflow_d = 1'b0;
      end
      if (ovfSet) begin
         overflow_d = 1'b1;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (UartDataBits),
      .DEPTH        (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .usage_o (fifoUsage),
      .data_i  (shift_q),
      .push_i  (pushByte),
      .data_o  (fifoData),
      .pop_i   (popByte)
   );

   assign cons.byte_o  = fifoData;
   assign cons.valid_o = !fifoEmpty;
   assign cons.eol_o   = !fifoEmpty && (fifoData == UartEol);
   assign frame_err_o  = frameErr_q;
   assign overflow_o   = overflow_q;
   assign fill_o       = fifoUsage;

endmodule

// File: tb/tb_vip_uart_rx_capture.sv
// Directed self-checking bench for the UART receive capture block.
module tb_vip_uart_rx_capture;

   localparam int ClksPerBit = 16;
   localparam int FifoDepth  = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       clr;
   logic       frameErr;
   logic       overflow;
   logic [3:0] fill;

   int checks = 0;
   int fails  = 0;

   logic       monClr = 1'b1;
   int         validCnt;
   int         eolCnt;
   int         ferrCnt;
   logic [7:0] lastByte;

   vip_uart_rx_capture_if bus();

   vip_uart_rx_capture #(
      .ClksPerBit (ClksPerBit),
      .FifoDepth  (FifoDepth)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_i        (rx),
      .clr_i       (clr),
      .cons        (bus),
      .frame_err_o (frameErr),
      .overflow_o  (overflow),
      .fill_o      (fill)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Monitor on the falling edge: counts accepted bytes, EOL pops and error pulses.
   always @(negedge clk) begin
      if (monClr) begin
         validCnt = 0;
         eolCnt   = 0;
         ferrCnt  = 0;
         lastByte = 8'h00;
      end else begin
         if (bus.valid_o && bus.ready_i) begin
            validCnt++;
            lastByte = bus.byte_o;
            if (bus.eol_o) eolCnt++;
         end
         if (frameErr) ferrCnt++;
      end
   end

   // Advance one clock; inputs change and outputs are read 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearMonitor();
      monClr = 1'b1;
      tick();
      monClr = 1'b0;
   endtask

   // Drive one 8N1 frame. The DUT samples the stop bit on the 155th edge after
   // the start bit is driven; popAtPush raises ready_i for exactly that edge.
   task automatic sendByte(input logic [7:0] b, input logic stopBit, input int extraLow,
                           input bit popAtPush);
      for (int c = 0; c < 160 + extraLow; c++) begin
         tick();
         if (c < 16)       rx = 1'b0;
         else if (c < 144) rx = b[3'((c - 16) / 16)];
         else if (c < 160) rx = stopBit;
         else              rx = 1'b0;
         if (popAtPush) bus.ready_i = (c == 154);
      end
      tick();
      rx = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      clr = 1'b0;
      bus.ready_i = 1'b0;
      repeat (3) tick();
      checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_o); end
      checks++; if (bus.eol_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_eol: got %b expected 0", bus.eol_o); end
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL reset_fill: got %0d expected 0", fill); end
      checks++; if (frameErr !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frameErr); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (bus.byte_o !== 8'h00) begin fails++; $display("[TB] FAIL reset_byte: got %h expected 00", bus.byte_o); end
      rst_n = 1'b1;
      repeat (4) tick();
      clearMonitor();
   endtask

   task automatic test_single_byte();
      bus.ready_i = 1'b1;
      clearMonitor();
      sendByte(8'h41, 1'b1, 0, 1'b0);
      checks++; if (validCnt !== 1) begin fails++; $display("[TB] FAIL single_pops: got %0d expected 1", validCnt); end
      checks++; if (lastByte !== 8'h41) begin fails++; $display("[TB] FAIL single_byte: got %h expected 41", lastByte); end
      checks++; if (eolCnt !== 0) begin fails++; $display("[TB] FAIL single_eol: got %0d expected 0", eolCnt); end
      checks++; if (ferrCnt !== 0) begin fails++; $display("[TB] FAIL single_frame_err: got %0d expected 0", ferrCnt); end
      bus.ready_i = 1'b0;
   endtask

   task automatic test_eol_line();
      logic [7:0] exp [3];
      logic       expEol [3];
      exp = '{8'h48, 8'h69, 8'h0A};
      expEol = '{1'b0, 1'b0, 1'b1};
      bus.ready_i = 1'b0;
      for (int i = 0; i < 3; i++) sendByte(exp[i], 1'b1, 0, 1'b0);
      checks++; if (fill !== 4'd3) begin fails++; $display("[TB] FAIL line_fill: got %0d expected 3", fill); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.byte_o !== exp[i]) begin fails++; $display("[TB] FAIL line_byte%0d: got %h expected %h", i, bus.byte_o, exp[i]); end
         checks++; if (bus.eol_o !== expEol[i]) begin fails++; $display("[TB] FAIL line_eol%0d: got %b expected %b", i, bus.eol_o, expEol[i]); end
         bus.ready_i = 1'b1;
         tick();
         bus.ready_i = 1'b0;
      end
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL line_drained: got %0d expected 0", fill); end
   endtask

   task automatic test_frame_error();
      clearMonitor();
      sendByte(8'h55, 1'b0, 16, 1'b0);
      checks++; if (ferrCnt !== 1) begin fails++; $display("[TB] FAIL ferr_pulse_cycles: got %0d expected 1", ferrCnt); end
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL ferr_fill: got %0d expected 0", fill); end
      sendByte(8'h5A, 1'b1, 0, 1'b0);
      checks++; if (fill !== 4'd1) begin fails++; $display("[TB] FAIL ferr_recover_fill: got %0d expected 1", fill); end
      checks++; if (bus.byte_o !== 8'h5A) begin fails++; $display("[TB] FAIL ferr_recover_byte: got %h expected 5a", bus.byte_o); end
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
   endtask

   task automatic test_glitch();
      clearMonitor();
      repeat (4) begin tick(); rx = 1'b0; end
      tick();
      rx = 1'b1;
      repeat (200) tick();
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL glitch_fill: got %0d expected 0", fill); end
      checks++; if (ferrCnt !== 0) begin fails++; $display("[TB] FAIL glitch_frame_err: got %0d expected 0", ferrCnt); end
      checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL glitch_valid: got %b expected 0", bus.valid_o); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      bus.ready_i = 1'b0;
      for (int i = 1; i <= 9; i++) sendByte(8'(i), 1'b1, 0, 1'b0);
      checks++; if (fill !== 4'd8) begin fails++; $display("[TB] FAIL ovf_fill: got %0d expected 8", fill); end
      checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
      sendByte(8'h0A, 1'b1, 0, 1'b1);
      checks++; if (fill !== 4'd8) begin fails++; $display("[TB] FAIL ovf_pushpop_fill: got %0d expected 8", fill); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_pushpop_flag: got %b expected 0", overflow); end
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 8'(i + 2) : 8'h0A;
         checks++; if (bus.byte_o !== exp) begin fails++; $display("[TB] FAIL ovf_drain%0d: got %h expected %h", i, bus.byte_o, exp); end
         bus.ready_i = 1'b1;
         tick();
         bus.ready_i = 1'b0;
      end
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL ovf_drained: got %0d expected 0", fill); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] partial;
      partial = 8'hA5;
      for (int c = 0; c < 160; c++) begin
         tick();
         if (c < 16)       rx = 1'b0;
         else if (c < 144) rx = partial[3'((c - 16) / 16)];
         else              rx = 1'b1;
         if (c == 84) rst_n = 1'b0;
      end
      repeat (4) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL midrst_fill: got %0d expected 0", fill); end
      sendByte(8'h3C, 1'b1, 0, 1'b0);
      checks++; if (fill !== 4'd1) begin fails++; $display("[TB] FAIL midrst_after_fill: got %0d expected 1", fill); end
      checks++; if (bus.byte_o !== 8'h3C) begin fails++; $display("[TB] FAIL midrst_byte: got %h expected 3c", bus.byte_o); end
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL midrst_drained: got %0d expected 0", fill); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_eol_line();
      test_frame_error();
      test_glitch();
      test_overflow();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
